// File: rtl/pixel_row_accumulator_pkg.sv
// Shared types and constants for the pixel row accumulator front end.
package pixel_row_accumulator_pkg;

  localparam int DATA_WIDTH_8         = 8;
  localparam int DATA_WIDTH_16        = 16;
  localparam int DEFAULT_FRAME_WIDTH  = 10;
  localparam int DEFAULT_FRAME_HEIGHT = 10;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_e;

endpackage

// File: rtl/pixel_row_accumulator_position.sv
// Frame position counter: tracks (x, y) of the next pixel, decodes line and
// frame boundaries for the pixel being accepted this cycle.
module frame_position_counter #(
  parameter int FRAME_WIDTH  = 10,
  parameter int FRAME_HEIGHT = 10
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        restart,     // current pixel position forced to (0,0)
  input  logic        advance,     // a pixel is accepted this cycle
  output logic [15:0] x,           // column of the pixel accepted this cycle
  output logic [15:0] y,           // line of the pixel accepted this cycle
  output logic        line_end,
  output logic        frame_done,
  output logic        at_last      // stored position is the last pixel
);

  localparam logic [15:0] X_LAST = 16'(FRAME_WIDTH - 1);
  localparam logic [15:0] Y_LAST = 16'(FRAME_HEIGHT - 1);

  logic [15:0] x_q, x_d;
  logic [15:0] y_q, y_d;

  // Effective position, boundary decode and next-position computation.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can leave it unassigned and infer a latch.
    x_d        = x_q;
    y_d        = y_q;
    x          = restart ? '0 : x_q;
    y          = restart ? '0 : y_q;
    line_end   = (x == X_LAST);
    frame_done = line_end && (y == Y_LAST);
    at_last    = (x_q == X_LAST) && (y_q == Y_LAST);
    if (advance) begin
      if (frame_done) begin
        x_d = '0;
        y_d = '0;
      end else if (line_end) begin
        x_d = '0;
        y_d = y + 16'd1;
      end else begin
        x_d = x + 16'd1;
        y_d = y;
      end
    end else if (restart) begin
      x_d = '0;
      y_d = '0;
    end
  end

  // Position registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      x_q <= '0;
      y_q <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
      x_q <= x_d;
      y_q <= y_d;
    end
  end

endmodule

// File: rtl/pixel_row_accumulator.sv
// Pixel row accumulator: accepts a raw pixel stream, tracks frame position,
// and emits one registered running row sum plus write strobe per pixel.
module pixel_row_accumulator #(
  parameter int DATA_WIDTH_8        = pixel_row_accumulator_pkg::DATA_WIDTH_8,
  parameter int DATA_WIDTH_16       = pixel_row_accumulator_pkg::DATA_WIDTH_16,
  parameter int FRAME_CAMERA_WIDTH  = pixel_row_accumulator_pkg::DEFAULT_FRAME_WIDTH,
  parameter int FRAME_CAMERA_HEIGHT = pixel_row_accumulator_pkg::DEFAULT_FRAME_HEIGHT
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     sof,
  input  logic                     pixel_valid,
  input  logic [DATA_WIDTH_8-1:0]  pixel_in,
  output logic                     o_wen,
  output logic [DATA_WIDTH_16-1:0] o_row_sum,
  output logic [15:0]              o_x,
  output logic [15:0]              o_y,
  output logic                     o_line_end,
  output logic                     o_frame_done,
  output logic                     o_frame_abort,
  output logic [7:0]               o_drop_count
);

  import pixel_row_accumulator_pkg::*;

  state_e                   state_q, state_d;
  logic                     wen_q, wen_d;
  logic [DATA_WIDTH_16-1:0] row_sum_q, row_sum_d;
  logic [15:0]              x_q, x_d;
  logic [15:0]              y_q, y_d;
  logic                     line_end_q, line_end_d;
  logic                     frame_done_q, frame_done_d;
  logic                     frame_abort_q, frame_abort_d;
  logic [7:0]               drop_count_q, drop_count_d;

  logic        accept;
  logic        restart;
  logic        pos_line_end;
  logic        pos_frame_done;
  logic        pos_at_last;
  logic [15:0] pos_x;
  logic [15:0] pos_y;

  frame_position_counter #(
    .FRAME_WIDTH  (FRAME_CAMERA_WIDTH),
    .FRAME_HEIGHT (FRAME_CAMERA_HEIGHT)
  ) u_position (
    .clk        (clk),
    .reset_n    (reset_n),
    .restart    (restart),
    .advance    (accept),
    .x          (pos_x),
    .y          (pos_y),
    .line_end   (pos_line_end),
    .frame_done (pos_frame_done),
    .at_last    (pos_at_last)
  );

  // Acceptance, frame restart/abort decisions, next state and output datapath.
  always_comb begin
    logic last_with_sof;
    state_d       = state_q;
    drop_count_d  = drop_count_q;
    row_sum_d     = row_sum_q;
    x_d           = x_q;
    y_d           = y_q;
    accept        = pixel_valid && ((state_q == ST_ACTIVE) || sof);
    // A sof arriving with the frame's last pixel lets that pixel finish the
    // frame; the new frame then begins with the following pixel.
    last_with_sof = (state_q == ST_ACTIVE) && sof && pixel_valid && pos_at_last;
    restart       = sof && !last_with_sof;
    frame_abort_d = sof && (state_q == ST_ACTIVE) && !last_with_sof;

    case (state_q)
      ST_IDLE: begin
        if (sof) begin
          state_d = (accept && pos_frame_done) ? ST_IDLE : ST_ACTIVE;
        end else if (pixel_valid && (drop_count_q != 8'd255)) begin
          drop_count_d = drop_count_q + 8'd1;
        end
      end
      ST_ACTIVE: begin
        if (accept && pos_frame_done && !sof) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (accept) begin
      row_sum_d = ((pos_x == 16'd0) ? '0 : row_sum_q)
                + {{(DATA_WIDTH_16 - DATA_WIDTH_8){1'b0}}, pixel_in};
      x_d       = pos_x;
      y_d       = pos_y;
    end
    wen_d        = accept;
    line_end_d   = accept && pos_line_end;
    frame_done_d = accept && pos_frame_done;
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: reset clears every flop so a mid-frame reset leaves no stale frame state or abort pulse behind.
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      wen_q         <= 1'b0;
      row_sum_q     <= '0;
      x_q           <= '0;
      y_q           <= '0;
      line_end_q    <= 1'b0;
      frame_done_q  <= 1'b0;
      frame_abort_q <= 1'b0;
      drop_count_q  <= '0;
    end else begin
      state_q       <= state_d;
      wen_q         <= wen_d;
      row_sum_q     <= row_sum_d;
      x_q           <= x_d;
      y_q           <= y_d;
      line_end_q    <= line_end_d;
      frame_done_q  <= frame_done_d;
      frame_abort_q <= frame_abort_d;
      drop_count_q  <= drop_count_d;
    end
  end

  assign o_wen         = wen_q;
  assign o_row_sum     = row_sum_q;
  assign o_x           = x_q;
  assign o_y           = y_q;
  assign o_line_end    = line_end_q;
  assign o_frame_done  = frame_done_q;
  assign o_frame_abort = frame_abort_q;
  assign o_drop_count  = drop_count_q;

endmodule

// File: tb/tb_pixel_row_accumulator.sv
// Self-checking bench for pixel_row_accumulator against a frame-index model.
module tb_pixel_row_accumulator;

  localparam int W = 10;
  localparam int H = 10;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        sof;
  logic        pixel_valid;
  logic [7:0]  pixel_in;
  logic        o_wen;
  logic [15:0] o_row_sum;
  logic [15:0] o_x;
  logic [15:0] o_y;
  logic        o_line_end;
  logic        o_frame_done;
  logic        o_frame_abort;
  logic [7:0]  o_drop_count;

  pixel_row_accumulator #(
    .DATA_WIDTH_8        (8),
    .DATA_WIDTH_16       (16),
    .FRAME_CAMERA_WIDTH  (W),
    .FRAME_CAMERA_HEIGHT (H)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .sof           (sof),
    .pixel_valid   (pixel_valid),
    .pixel_in      (pixel_in),
    .o_wen         (o_wen),
    .o_row_sum     (o_row_sum),
    .o_x           (o_x),
    .o_y           (o_y),
    .o_line_end    (o_line_end),
    .o_frame_done  (o_frame_done),
    .o_frame_abort (o_frame_abort),
    .o_drop_count  (o_drop_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fails  = 0;
  int wen_pulses;

  // Reference model: a frame is a sequence of W*H pixels indexed by m_n;
  // position is derived arithmetically, the row sum from the line's pixels.
  bit m_in_frame;
  int m_n;
  int m_line[$];
  int m_drops;
  int m_wen, m_le, m_fd, m_abort, m_x, m_y, m_sum;

  task automatic model_reset();
    m_in_frame = 0; m_n = 0; m_line.delete(); m_drops = 0;
    m_wen = 0; m_le = 0; m_fd = 0; m_abort = 0; m_x = 0; m_y = 0; m_sum = 0;
  endtask

  task automatic model_emit(input int pix);
    m_x = m_n % W;
    m_y = m_n / W;
    if (m_x == 0) m_line.delete();
    m_line.push_back(pix);
    m_sum = 0;
    foreach (m_line[i]) m_sum += m_line[i];
    m_sum = m_sum % 65536;
    m_wen = 1;
    m_le  = (m_x == W - 1) ? 1 : 0;
    m_fd  = (m_n == W * H - 1) ? 1 : 0;
    m_n++;
    if (m_fd == 1) begin
      m_in_frame = 0;
      m_n = 0;
    end
  endtask

  task automatic model_cycle(input bit s, input bit v, input int pix);
    m_wen = 0; m_le = 0; m_fd = 0; m_abort = 0;
    if (!m_in_frame) begin
      if (s) begin
        m_in_frame = 1;
        m_n = 0;
        if (v) model_emit(pix);
      end else if (v && m_drops < 255) begin
        m_drops++;
      end
    end else if (s) begin
      if (v && m_n == W * H - 1) begin
        model_emit(pix);
        m_in_frame = 1;
        m_n = 0;
      end else begin
        m_abort = 1;
        m_n = 0;
        if (v) model_emit(pix);
      end
    end else if (v) begin
      model_emit(pix);
    end
  endtask

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    check("wen",         int'(o_wen),         m_wen);
    check("row_sum",     int'(o_row_sum),     m_sum);
    check("x",           int'(o_x),           m_x);
    check("y",           int'(o_y),           m_y);
    check("line_end",    int'(o_line_end),    m_le);
    check("frame_done",  int'(o_frame_done),  m_fd);
    check("frame_abort", int'(o_frame_abort), m_abort);
    check("drop_count",  int'(o_drop_count),  m_drops);
  endtask

  task automatic step(input bit s, input bit v, input int pix);
    sof         = s;
    pixel_valid = v;
    pixel_in    = 8'(pix);
    model_cycle(s, v, pix);
    @(posedge clk);
    #1;
    check_all();
    wen_pulses += int'(o_wen);
    sof         = 1'b0;
    pixel_valid = 1'b0;
  endtask

  initial begin
    int guard;
    reset_n = 1'b0; sof = 1'b0; pixel_valid = 1'b0; pixel_in = 8'd0;
    wen_pulses = 0;
    model_reset();
    #12;
    check_all();
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // Line of ones: sums 1..10, line end at x=9, then next line restarts.
    step(1, 1, 1);
    for (int i = 0; i < 9; i++) step(0, 1, 1);
    check("line0_sum", int'(o_row_sum), 10);
    check("line0_end", int'(o_line_end), 1);
    step(0, 1, 1);
    check("line1_first_sum", int'(o_row_sum), 1);
    check("line1_y", int'(o_y), 1);

    // Full frame of 255 (aborts the partial frame above).
    step(1, 1, 255);
    for (int i = 1; i < W * H; i++) begin
      step(0, 1, 255);
      if (i % W == W - 1) check("line_sum_2550", int'(o_row_sum), 2550);
    end
    check("frame_done_99", int'(o_frame_done), 1);
    step(0, 1, 3);
    check("drop_after_frame", int'(o_drop_count), 1);

    // 300 pixels without sof: nothing emitted, drop count saturates.
    wen_pulses = 0;
    for (int i = 0; i < 300; i++) step(0, 1, int'($urandom_range(0, 255)));
    check("no_wen_in_idle", wen_pulses, 0);
    check("drop_saturated", int'(o_drop_count), 255);

    // sof without pixel, then a gapped random frame up to (4,3), then abort.
    step(1, 0, 0);
    guard = 0;
    while (m_n != 34 && guard < 2000) begin
      step(0, bit'($urandom_range(0, 1)), int'($urandom_range(0, 255)));
      guard++;
    end
    check("reach_4_3_in_budget", int'(guard < 2000), 1);
    step(1, 1, 7);
    check("abort_pulse", int'(o_frame_abort), 1);
    check("abort_wen", int'(o_wen), 1);
    check("abort_x", int'(o_x), 0);
    check("abort_y", int'(o_y), 0);
    check("abort_sum", int'(o_row_sum), 7);

    // Run to (9,9) and present sof with the last pixel.
    guard = 0;
    while (m_n != W * H - 1 && guard < 2000) begin
      step(0, bit'($urandom_range(0, 1)), int'($urandom_range(0, 255)));
      guard++;
    end
    check("reach_9_9_in_budget", int'(guard < 2000), 1);
    step(1, 1, int'($urandom_range(0, 255)));
    check("coincident_done", int'(o_frame_done), 1);
    check("coincident_no_abort", int'(o_frame_abort), 0);
    step(0, 1, 20);
    check("new_frame_x", int'(o_x), 0);
    check("new_frame_y", int'(o_y), 0);
    check("new_frame_sum", int'(o_row_sum), 20);

    // Random traffic with occasional sof.
    for (int i = 0; i < 400; i++)
      step(bit'($urandom_range(0, 63) == 0), bit'($urandom_range(0, 3) != 0),
           int'($urandom_range(0, 255)));

    // Toggled valid across a line, then asynchronous reset mid-line.
    step(1, 1, 5);
    for (int i = 0; i < 6; i++) step(0, bit'(i % 2), int'($urandom_range(0, 255)));
    #2;
    reset_n = 1'b0;
    #1;
    model_reset();
    check_all();
    #2;
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) step(0, 1, 9);
    check("drops_after_reset", int'(o_drop_count), 3);
    check("no_wen_after_reset", int'(o_wen), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/pixel_row_accumulator.md
# pixel_row_accumulator

Front-end stage of the face detection integral pipeline. Takes the raw 8-bit camera pixel stream and produces one 16-bit horizontal running row sum per accepted pixel. Also produces the write strobe that drives the first row-integral line buffer stage (its `wen` / `fifo_in`). It tracks frame position (x, y) and frame boundaries, so downstream stages see a clean, frame-aligned stream.

## Interface
Parameters:
- DATA_WIDTH_8, 8, pixel width
- DATA_WIDTH_16, 16, row-sum / output data width
- FRAME_CAMERA_WIDTH, 10, pixels per line
- FRAME_CAMERA_HEIGHT, 10, lines per frame

Ports:
- clk  in  1  system clock; all logic on rising edge
- reset_n  in  1  asynchronous, active-low reset
- sof  in  1  start-of-frame pulse, one cycle, marks the first pixel of a frame
- pixel_valid  in  1  pixel_in valid this cycle
- pixel_in  in  8  grey pixel
- o_wen  out  1  write strobe to the row stage; registered
- o_row_sum  out  16  running sum of the current line, pixels 0..x inclusive
- o_x  out  16  column of the pixel just emitted
- o_y  out  16  line of the pixel just emitted
- o_line_end  out  1  emitted pixel is the last of its line
- o_frame_done  out  1  emitted pixel is the last of the frame
- o_frame_abort  out  1  one-cycle pulse: a frame was restarted before completion
- o_drop_count  out  8  saturating count of pixels discarded in IDLE

## Operation
- Two states: IDLE and ACTIVE. Reset state is IDLE.
- **IDLE**
  - pixel_valid without sof: pixel discarded; o_drop_count increments, saturating at 255.
  - sof with pixel_valid: pixel accepted as (x=0, y=0); go to ACTIVE.
  - sof without pixel_valid: go to ACTIVE with x=0, y=0 pending; the next valid pixel becomes (0,0).
- **ACTIVE**, each accepted pixel:
  - sum_next = (x==0 ? 0 : sum) + pixel_in, modulo 2^16 (zero-extended add, no saturation).
  - Emit the registered result; then x increments.
  - At x = FRAME_CAMERA_WIDTH-1: o_line_end=1, x wraps to 0, sum clears, y increments.
- Last pixel of the frame (x = W-1, y = H-1): o_frame_done=1, state returns to IDLE, x and y clear.
- **sof while in ACTIVE, before the last pixel**
  - o_frame_abort pulses.
  - x, y and sum restart at 0; state stays ACTIVE.
  - If pixel_valid is also high, that pixel is (0,0) of the new frame.
- **sof coincident with the last pixel of a frame**
  - The last pixel completes normally, with o_frame_done=1 and no abort.
  - The new frame starts: state goes to ACTIVE (not IDLE).
- pixel_valid low in ACTIVE: nothing is emitted and all state holds. Gaps of any length are allowed.
- o_drop_count clears only on reset.

## Timing
- Latency is 1 cycle: a pixel accepted at edge N appears on o_* after edge N, and o_wen is high for exactly that one cycle.
- o_x, o_y, o_row_sum, o_line_end and o_frame_done are valid only while o_wen=1. They hold their last values otherwise; flags are 0 when o_wen=0.
- Throughput: one pixel per cycle, with no backpressure.
- o_frame_abort is registered and asserts in the same cycle as the o_wen of the restarted (0,0) pixel, or on its own cycle if no pixel accompanied sof.
- Reset values: all outputs 0, state IDLE, counters 0. Reset mid-frame drops the frame silently (no abort pulse).

## Structure
- Shared package holds:
  - the state enum (IDLE, ACTIVE);
  - the width constants DATA_WIDTH_8 and DATA_WIDTH_16;
  - the default frame dimensions.
- One natural sub-module: `frame_position_counter` (x/y counters, wrap, line_end/frame_done decode). The accumulator and FSM stay in the top.

## Test plan
- Reset, then sof with pixel_valid, then 10 consecutive pixels of value 1 -> o_row_sum 1..10, o_x 0..9, o_line_end only on x=9, next pixel sum=1 at y=1.
- Full 10x10 frame of value 255 -> every line ends with sum 2550; o_frame_done on pixel (9,9); state IDLE; subsequent pixel_valid without sof increments o_drop_count.
- 300 pixels with pixel_valid but no sof -> zero o_wen pulses; o_drop_count saturates at 255.
- sof at pixel (4,3) with pixel_valid and pixel 7 -> o_frame_abort=1 alongside o_wen, o_x=0, o_y=0, o_row_sum=7.
- sof coincident with pixel (9,9) -> o_frame_done=1, no abort; the next valid pixel is emitted as (0,0) of the new frame.
- pixel_valid toggled 1/0 across a line, with reset_n pulled low mid-line -> all outputs 0 asynchronously; after release, pixels are ignored (counted as drops) until sof.
